// File: rtl/mips_pkg.sv
// Shared multicycle-MIPS definitions: opcodes, next-PC select encodings and reset PC.
package mips_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   // jr is an R-type instruction; FUNCT_JR distinguishes it inside the controller
   localparam logic [OP_W-1:0] OP_JR    = 6'b000000;
   localparam logic [OP_W-1:0] FUNCT_JR = 6'b001000;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

   typedef enum logic [1:0] {
      PCSRC_ALU = 2'b00,
      PCSRC_BRJ = 2'b01,
      PCSRC_REG = 2'b10,
      PCSRC_RSV = 2'b11
   } pcsrc_e;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   function automatic logic is_jump(input logic [OP_W-1:0] op);
      return (op == OP_J) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/pc_ir_sequencer_if.sv
// Controller/memory-facing signal bundle of the PC/IR register stage.
interface pc_ir_sequencer_if #(
   parameter int unsigned COUNT_W = 32
);
   logic                 pc_write;
   logic                 pc_write_condition_beq;
   logic                 pc_write_condition_bne;
   logic                 zero;
   mips_pkg::pcsrc_e     pcsrc;
   logic                 IorD;
   logic                 IR_write;
   logic [31:0]          alu_result;
   logic [31:0]          reg_a;
   logic [31:0]          mem_rdata;

   logic [31:0]          pc;
   logic [31:0]          mem_addr;
   logic [31:0]          ir;
   logic [5:0]           opcode;
   logic [31:0]          mdr;
   logic [31:0]          alu_out;
   logic [COUNT_W-1:0]   fetch_count;
   logic [COUNT_W-1:0]   cycle_count;
   logic                 misalign_err;

   modport master (
      output pc_write, pc_write_condition_beq, pc_write_condition_bne, zero,
             pcsrc, IorD, IR_write, alu_result, reg_a, mem_rdata,
      input  pc, mem_addr, ir, opcode, mdr, alu_out, fetch_count, cycle_count,
             misalign_err
   );

   modport slave (
      input  pc_write, pc_write_condition_beq, pc_write_condition_bne, zero,
             pcsrc, IorD, IR_write, alu_result, reg_a, mem_rdata,
      output pc, mem_addr, ir, opcode, mdr, alu_out, fetch_count, cycle_count,
             misalign_err
   );
endinterface

// File: rtl/pc_ir_sequencer_pc_next_sel.sv
// Next-PC target mux, PC load enable and misaligned-target detection.
module pc_next_sel
   import mips_pkg::*;
(
   input  logic [3:0]  pc_hi,
   input  logic [31:0] ir,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_out,
   input  logic [31:0] reg_a,
   input  pcsrc_e      pcsrc,
   input  logic        pc_write,
   input  logic        beq,
   input  logic        bne,
   input  logic        zero,
   output logic        load_c,
   output logic [31:0] target_c,
   output logic        misalign_c
);

   logic [31:0] raw;
   logic        pc_en;

   // Jump targets are built from the pre-edge ir and pc, never the incoming word
   always_comb begin
      raw = alu_result;
      case (pcsrc)
         PCSRC_ALU: raw = alu_result;
         PCSRC_BRJ: raw = is_jump(ir[31:26]) ? {pc_hi, ir[25:0], 2'b00} : alu_out;
         PCSRC_REG: raw = reg_a;
         default:   raw = alu_result;
      endcase
   end

   assign pc_en      = pc_write | (beq & zero) | (bne & ~zero);
   assign load_c     = pc_en & (pcsrc != PCSRC_RSV);
   assign target_c   = {raw[31:2], 2'b00};
   assign misalign_c = load_c & (raw[1:0] != 2'b00);

endmodule

// File: rtl/pc_ir_sequencer.sv
// Multicycle datapath register stage: PC, IR, MDR, ALUOut plus bring-up debug counters.
module pc_ir_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned COUNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   pc_ir_sequencer_if.slave  bus
);

   logic [31:0]        pc_q;
   logic [31:0]        ir_q;
   logic [31:0]        mdr_q;
   logic [31:0]        alu_out_q;
   logic [COUNT_W-1:0] fetch_q;
   logic [COUNT_W-1:0] cycle_q;
   logic               misalign_q;

   logic               load_c;
   logic [31:0]        target_c;
   logic               misalign_c;

   pc_next_sel u_pc_next_sel (
      .pc_hi      (pc_q[31:28]),
      .ir         (ir_q),
      .alu_result (bus.alu_result),
      .alu_out    (alu_out_q),
      .reg_a      (bus.reg_a),
      .pcsrc      (bus.pcsrc),
      .pc_write   (bus.pc_write),
      .beq        (bus.pc_write_condition_beq),
      .bne        (bus.pc_write_condition_bne),
      .zero       (bus.zero),
      .load_c     (load_c),
      .target_c   (target_c),
      .misalign_c (misalign_c)
   );

   // MDR and ALUOut capture every cycle; PC/IR only on their strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         mdr_q      <= '0;
         alu_out_q  <= '0;
         fetch_q    <= '0;
         cycle_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         mdr_q     <= bus.mem_rdata;
         alu_out_q <= bus.alu_result;
         cycle_q   <= cycle_q + COUNT_W'(1);
         if (load_c) pc_q <= target_c;
         if (misalign_c) misalign_q <= 1'b1;
         if (bus.IR_write) begin
            ir_q    <= bus.mem_rdata;
            fetch_q <= fetch_q + COUNT_W'(1);
         end
      end
   end

   assign bus.pc           = pc_q;
   assign bus.ir           = ir_q;
   assign bus.mdr          = mdr_q;
   assign bus.alu_out      = alu_out_q;
   assign bus.fetch_count  = fetch_q;
   assign bus.cycle_count  = cycle_q;
   assign bus.misalign_err = misalign_q;
   assign bus.mem_addr     = bus.IorD ? alu_out_q : pc_q;
   assign bus.opcode       = ir_q[31:26];

endmodule

// File: tb/tb_pc_ir_sequencer.sv
// Directed self-checking bench for pc_ir_sequencer.
module tb_pc_ir_sequencer;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   exp_cyc = 0;

   pc_ir_sequencer_if #(.COUNT_W(32)) bus ();

   pc_ir_sequencer #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      exp_cyc++;
   endtask

   task automatic idle_inputs();
      bus.pc_write = 0; bus.pc_write_condition_beq = 0; bus.pc_write_condition_bne = 0;
      bus.zero = 0; bus.IR_write = 0; bus.IorD = 0; bus.pcsrc = PCSRC_ALU;
   endtask

   task automatic test_reset();
      reset = 1;
      idle_inputs();
      bus.IR_write = 1; bus.pc_write = 1; bus.alu_result = 32'h1234_5678;
      bus.mem_rdata = 32'hFFFF_FFFF; bus.reg_a = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); end
      checks++; if (bus.ir !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h expected %h", bus.ir, 32'h0); end
      checks++; if (bus.mdr !== 32'h0) begin errors++; $display("FAIL reset_mdr: got %h expected %h", bus.mdr, 32'h0); end
      checks++; if (bus.alu_out !== 32'h0) begin errors++; $display("FAIL reset_alu_out: got %h expected %h", bus.alu_out, 32'h0); end
      checks++; if (bus.cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cycle: got %0d expected 0", bus.cycle_count); end
      checks++; if (bus.fetch_count !== 32'd0) begin errors++; $display("FAIL reset_fetch: got %0d expected 0", bus.fetch_count); end
      checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", bus.misalign_err); end
      checks++; if (bus.opcode !== 6'd0) begin errors++; $display("FAIL reset_opcode: got %b expected 000000", bus.opcode); end
      @(negedge clk);
      reset = 0;
      idle_inputs();
      bus.mem_rdata = 0; bus.alu_result = 0;
      exp_cyc = 0;
   endtask

   task automatic test_fetch();
      bus.IR_write = 1; bus.pc_write = 1; bus.pcsrc = PCSRC_ALU; bus.IorD = 0;
      bus.mem_rdata = 32'h2008_0005;
      #1;
      checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL fetch0_addr: got %h expected %h", bus.mem_addr, 32'h0); end
      for (int i = 1; i <= 3; i++) begin
         bus.alu_result = 32'(i * 4);
         tick();
         checks++; if (bus.pc !== 32'(i * 4)) begin errors++; $display("FAIL fetch_pc[%0d]: got %h expected %h", i, bus.pc, 32'(i * 4)); end
         checks++; if (bus.mem_addr !== 32'(i * 4)) begin errors++; $display("FAIL fetch_addr[%0d]: got %h expected %h", i, bus.mem_addr, 32'(i * 4)); end
      end
      idle_inputs();
      checks++; if (bus.ir !== 32'h2008_0005) begin errors++; $display("FAIL fetch_ir: got %h expected %h", bus.ir, 32'h2008_0005); end
      checks++; if (bus.opcode !== 6'b001000) begin errors++; $display("FAIL fetch_opcode: got %b expected 001000", bus.opcode); end
      checks++; if (bus.fetch_count !== 32'd3) begin errors++; $display("FAIL fetch_count: got %0d expected 3", bus.fetch_count); end
      checks++; if (bus.cycle_count !== 32'd3) begin errors++; $display("FAIL fetch_cycles: got %0d expected 3", bus.cycle_count); end
      checks++; if (bus.mdr !== 32'h2008_0005) begin errors++; $display("FAIL fetch_mdr: got %h expected %h", bus.mdr, 32'h2008_0005); end
      checks++; if (bus.alu_out !== 32'd12) begin errors++; $display("FAIL fetch_alu_out: got %h expected %h", bus.alu_out, 32'd12); end
   endtask

   task automatic test_jump();
      bus.pc_write = 1; bus.IR_write = 1; bus.pcsrc = PCSRC_ALU;
      bus.alu_result = 32'h1000_0010; bus.mem_rdata = 32'h0800_0040;
      tick();
      checks++; if (bus.pc !== 32'h1000_0010) begin errors++; $display("FAIL j_setup_pc: got %h expected %h", bus.pc, 32'h1000_0010); end
      bus.IR_write = 0; bus.pcsrc = PCSRC_BRJ; bus.alu_result = 32'h4;
      tick();
      checks++; if (bus.pc !== 32'h1000_0100) begin errors++; $display("FAIL j_pc: got %h expected %h", bus.pc, 32'h1000_0100); end
      // jal taken on the same edge a new instruction is latched: target uses the old ir
      bus.IR_write = 1; bus.pcsrc = PCSRC_ALU; bus.alu_result = 32'hA000_0004; bus.mem_rdata = 32'h0C00_0003;
      tick();
      bus.pcsrc = PCSRC_BRJ; bus.mem_rdata = 32'h0000_0000; bus.alu_result = 32'h4;
      tick();
      idle_inputs();
      checks++; if (bus.pc !== 32'hA000_000C) begin errors++; $display("FAIL jal_pc: got %h expected %h", bus.pc, 32'hA000_000C); end
      checks++; if (bus.ir !== 32'h0) begin errors++; $display("FAIL jal_ir: got %h expected %h", bus.ir, 32'h0); end
      checks++; if (bus.fetch_count !== 32'd6) begin errors++; $display("FAIL jal_fetch: got %0d expected 6", bus.fetch_count); end
      checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL jal_misalign: got %b expected 0", bus.misalign_err); end
   endtask

   task automatic set_pc_40_alu_80();
      idle_inputs();
      bus.pc_write = 1; bus.alu_result = 32'h40;
      tick();
      bus.pc_write = 0; bus.alu_result = 32'h80;
      tick();
   endtask

   task automatic test_branch();
      bus.pc_write = 1; bus.pcsrc = PCSRC_ALU; bus.alu_result = 32'h40;
      bus.IR_write = 1; bus.mem_rdata = 32'h1000_0000;
      tick();
      bus.IR_write = 0; bus.pc_write = 0; bus.alu_result = 32'h80;
      tick();
      checks++; if (bus.opcode !== OP_BEQ) begin errors++; $display("FAIL br_opcode: got %b expected 000100", bus.opcode); end
      checks++; if (bus.alu_out !== 32'h80) begin errors++; $display("FAIL br_alu_out: got %h expected %h", bus.alu_out, 32'h80); end
      bus.pcsrc = PCSRC_BRJ; bus.pc_write_condition_beq = 1; bus.zero = 0;
      tick();
      checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL beq_nt_pc: got %h expected %h", bus.pc, 32'h40); end
      bus.zero = 1;
      tick();
      checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL beq_t_pc: got %h expected %h", bus.pc, 32'h80); end
      set_pc_40_alu_80();
      bus.pcsrc = PCSRC_BRJ; bus.pc_write_condition_bne = 1; bus.zero = 1;
      tick();
      checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL bne_nt_pc: got %h expected %h", bus.pc, 32'h40); end
      bus.zero = 0;
      tick();
      checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL bne_t_pc: got %h expected %h", bus.pc, 32'h80); end
      set_pc_40_alu_80();
      bus.pcsrc = PCSRC_BRJ; bus.pc_write_condition_beq = 1; bus.pc_write_condition_bne = 1; bus.zero = 0;
      tick();
      idle_inputs();
      checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL beq_bne_pc: got %h expected %h", bus.pc, 32'h80); end
      checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL br_misalign: got %b expected 0", bus.misalign_err); end
      checks++; if (bus.fetch_count !== 32'd7) begin errors++; $display("FAIL br_fetch: got %0d expected 7", bus.fetch_count); end
   endtask

   task automatic test_jr();
      bus.pcsrc = PCSRC_REG; bus.reg_a = 32'h0000_0203; bus.pc_write = 1;
      tick();
      idle_inputs();
      checks++; if (bus.pc !== 32'h200) begin errors++; $display("FAIL jr_pc: got %h expected %h", bus.pc, 32'h200); end
      checks++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL jr_misalign: got %b expected 1", bus.misalign_err); end
      repeat (5) tick();
      checks++; if (bus.misalign_err !== 1'b1) begin errors++; $display("FAIL jr_sticky: got %b expected 1", bus.misalign_err); end
      checks++; if (bus.pc !== 32'h200) begin errors++; $display("FAIL jr_hold_pc: got %h expected %h", bus.pc, 32'h200); end
   endtask

   task automatic test_lw_reserved();
      bus.IorD = 1; bus.alu_result = 32'h44;
      tick();
      checks++; if (bus.alu_out !== 32'h44) begin errors++; $display("FAIL lw_alu_out: got %h expected %h", bus.alu_out, 32'h44); end
      checks++; if (bus.mem_addr !== 32'h44) begin errors++; $display("FAIL lw_addr: got %h expected %h", bus.mem_addr, 32'h44); end
      bus.mem_rdata = 32'hDEAD_BEEF;
      tick();
      checks++; if (bus.mdr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_mdr: got %h expected %h", bus.mdr, 32'hDEAD_BEEF); end
      bus.IorD = 0;
      #1;
      checks++; if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL pc_addr: got %h expected %h", bus.mem_addr, 32'h200); end
      bus.pcsrc = PCSRC_RSV; bus.pc_write = 1; bus.alu_result = 32'h301; bus.reg_a = 32'h301;
      tick();
      idle_inputs();
      checks++; if (bus.pc !== 32'h200) begin errors++; $display("FAIL rsv_pc: got %h expected %h", bus.pc, 32'h200); end
      checks++; if (bus.cycle_count !== 32'(exp_cyc)) begin errors++; $display("FAIL rsv_cycles: got %0d expected %0d", bus.cycle_count, exp_cyc); end
   endtask

   task automatic test_async_reset();
      bus.alu_result = 32'h88; bus.mem_rdata = 32'h1111_2222; bus.IR_write = 1;
      repeat (10) tick();
      bus.IR_write = 0;
      @(posedge clk);
      #3;
      reset = 1;
      #1;
      checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL arst_pc: got %h expected %h", bus.pc, 32'h0); end
      checks++; if (bus.cycle_count !== 32'd0) begin errors++; $display("FAIL arst_cycle: got %0d expected 0", bus.cycle_count); end
      checks++; if (bus.fetch_count !== 32'd0) begin errors++; $display("FAIL arst_fetch: got %0d expected 0", bus.fetch_count); end
      checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL arst_misalign: got %b expected 0", bus.misalign_err); end
      checks++; if (bus.ir !== 32'h0) begin errors++; $display("FAIL arst_ir: got %h expected %h", bus.ir, 32'h0); end
      checks++; if (bus.mdr !== 32'h0) begin errors++; $display("FAIL arst_mdr: got %h expected %h", bus.mdr, 32'h0); end
      @(negedge clk);
      reset = 0;
      exp_cyc = 0;
      bus.IR_write = 1; bus.pc_write = 1; bus.pcsrc = PCSRC_ALU; bus.IorD = 0;
      bus.alu_result = 32'h4; bus.mem_rdata = 32'h2008_0005;
      #1;
      checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL arst_fetch_addr: got %h expected %h", bus.mem_addr, 32'h0); end
      tick();
      idle_inputs();
      checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL arst_next_pc: got %h expected %h", bus.pc, 32'h4); end
      checks++; if (bus.fetch_count !== 32'd1) begin errors++; $display("FAIL arst_next_fetch: got %0d expected 1", bus.fetch_count); end
      checks++; if (bus.cycle_count !== 32'd1) begin errors++; $display("FAIL arst_next_cycle: got %0d expected 1", bus.cycle_count); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_jump();
      test_branch();
      test_jr();
      test_lw_reserved();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_ir_sequencer.md
Name: pc_ir_sequencer

Overview:
- Multicycle-datapath register stage directly downstream of the main FSM controller. Consumes pc_write, pc_write_condition_beq/bne, pcsrc, IorD and IR_write.
- Owns the PC, IR, MDR and ALUOut registers, the next-PC selection and the memory address mux.
- Feeds the opcode back to the controller.
- Adds a fetch counter, a cycle counter and a sticky misaligned-target flag for bring-up debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- COUNT_W, 32, width of the fetch and cycle counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pc_write  in  1  unconditional PC load.
- pc_write_condition_beq  in  1  load PC if zero=1.
- pc_write_condition_bne  in  1  load PC if zero=0.
- zero  in  1  ALU zero flag, same cycle as the condition strobes.
- pcsrc  in  2  next-PC select.
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut.
- IR_write  in  1  latch instruction from memory.
- alu_result  in  32  combinational ALU output.
- reg_a  in  32  register-file rs read data, used for jr.
- mem_rdata  in  32  combinational memory read data.
- pc  out  32  current PC; also the jal link value.
- mem_addr  out  32  memory address.
- ir  out  32  instruction register.
- opcode  out  6  ir[31:26], to the controller.
- mdr  out  32  memory data register.
- alu_out  out  32  ALUOut register.
- fetch_count  out  COUNT_W  number of IR loads.
- cycle_count  out  COUNT_W  clock cycles since reset.
- misalign_err  out  1  sticky flag: a PC target had bits [1:0] != 0.

Behaviour:
- Reset (async, active-high): pc=RESET_PC; ir, mdr, alu_out, fetch_count, cycle_count = 0; misalign_err = 0. Outputs hold these values while reset is high.
- Combinational outputs:
  - mem_addr = IorD ? alu_out : pc
  - opcode = ir[31:26]
- pc_en = pc_write | (pc_write_condition_beq & zero) | (pc_write_condition_bne & ~zero).
- Next-PC target:
  - pcsrc=00: alu_result (PC+4 during fetch).
  - pcsrc=01 and opcode is j (000010) or jal (000011): {pc[31:28], ir[25:0], 2'b00}.
  - pcsrc=01, any other opcode: alu_out (branch target computed in decode).
  - pcsrc=10: reg_a (jr).
  - pcsrc=11: reserved; PC holds even if pc_en=1; no error flag.
- PC load: on posedge when pc_en=1 and pcsrc!=11, pc <= {target[31:2], 2'b00}. If target[1:0] != 0, misalign_err <= 1. The flag is sticky until reset.
- IR: ir <= mem_rdata when IR_write=1; otherwise holds.
- MDR: mdr <= mem_rdata every cycle (gives 1-cycle latency for the lw writeback state).
- ALUOut: alu_out <= alu_result every cycle.
- Simultaneous events:
  - Fetch asserts IR_write and pc_write together: IR gets the old-PC instruction and PC gets alu_result in the same edge.
  - The jump target always uses the pre-edge ir and pc.
  - beq and bne both asserted: pc_en is the OR of both terms (never an error).
- Counters: cycle_count increments every clock out of reset. fetch_count increments on each IR_write. Both wrap modulo 2^COUNT_W; no saturation.
- Reset mid-operation: all state returns to reset values immediately; the next fetch comes from RESET_PC.
- No handshake: single-cycle memory, combinational read.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_JR, OP_ADDI, OP_ANDI, OP_LW, OP_SW
  - pcsrc encodings: PCSRC_ALU=00, PCSRC_BRJ=01, PCSRC_REG=10
  - RESET_PC default
- Sub-module pc_next_sel: combinational target mux plus pc_en and misalign detection. The remaining registers and counters stay in the top.

Test Plan:
- Reset then 3 fetch cycles (IR_write=1, pc_write=1, pcsrc=00, alu_result=pc+4), mem_rdata=32'h2008_0005 -> pc=0,4,8,12; ir=32'h2008_0005; opcode=001000; fetch_count=3.
- Jump with ir=32'h0800_0040, pc=32'h1000_0010, pcsrc=01, pc_write=1 -> pc=32'h1000_0100.
- beq taken/not taken with alu_out=32'h0000_0080, pcsrc=01, ir opcode 000100: zero=1 -> pc=0x80; zero=0 -> pc unchanged. bne with zero=0 -> pc=0x80.
- jr with reg_a=32'h0000_0203, pcsrc=10, pc_write=1 -> pc=32'h0000_0200, misalign_err=1 and still 1 after 5 further cycles.
- lw address: IorD=1, alu_out=32'h44 -> mem_addr=32'h44; mem_rdata=32'hDEAD_BEEF -> mdr=32'hDEAD_BEEF next cycle. pcsrc=11 with pc_write=1 -> pc holds.
- Assert reset asynchronously mid-cycle after 10 cycles -> pc=RESET_PC, counters=0, misalign_err=0 before the next clk edge.
